// File: rtl/ibex_rf_dump.sv
// Debug read-out engine: walks every register-file address through one read port and
// streams {data, address} beats. Define IBEX_RF_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module ibex_rf_dump #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [4:0]           raddr_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [4:0]           out_addr_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  // One extra counter bit so the "all words read" value NumWords is representable.
  localparam logic [5:0]  CntEnd   = 6'(NumWords);
  localparam logic [5:0]  CntLast  = 6'(NumWords - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] CSUM   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

`ifdef IBEX_RF_DUMP_CHECKSUM_EN
  localparam bit LastOnReg = 1'b0;
`else
  localparam bit LastOnReg = 1'b1;
`endif

  logic [1:0] state_q;
  logic [5:0] rd_cnt_q;
  logic [4:0] raddr_full;
  logic       handshake;
  logic       capture;
  logic       last_reg_hs;
  logic       start_ok;

  assign raddr_full = (rd_cnt_q == CntEnd) ? CntLast[4:0] : rd_cnt_q[4:0];
  assign raddr_o    = RV32E ? {1'b0, raddr_full[3:0]} : raddr_full;

  assign handshake   = out_valid_o & out_ready_i;
  assign start_ok    = (state_q == IDLE) & start_i & ~abort_i;
  assign capture     = (state_q == STREAM) & (~out_valid_o | out_ready_i) & (rd_cnt_q != CntEnd);
  // Once every word has been read, the only beat still outstanding is the last register.
  assign last_reg_hs = (state_q == STREAM) & handshake & (rd_cnt_q == CntEnd);

  assign busy_o = (state_q == STREAM) | (state_q == CSUM);
  assign done_o = (state_q == DONE);

`ifdef IBEX_RF_DUMP_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (capture) begin
      csum_q <= csum_q ^ rdata_i;
    end
  end
`endif

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_addr_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (abort_i) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q  <= STREAM;
            rd_cnt_q <= '0;
          end
        end
        STREAM: begin
          if (capture) begin
            out_valid_o <= 1'b1;
            out_data_o  <= rdata_i;
            out_addr_o  <= raddr_o;
            out_last_o  <= LastOnReg & (rd_cnt_q == CntLast);
            rd_cnt_q    <= rd_cnt_q + 6'd1;
          end else if (handshake) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
          end
          if (last_reg_hs) begin
`ifdef IBEX_RF_DUMP_CHECKSUM_EN
            // Checksum beat is loaded in the same edge so it follows with no bubble.
            state_q     <= CSUM;
            out_valid_o <= 1'b1;
            out_data_o  <= csum_q;
            out_addr_o  <= '0;
            out_last_o  <= 1'b1;
`else
            state_q     <= DONE;
`endif
          end
        end
        CSUM: begin
          if (handshake) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_rf_dump.sv
// Bench for ibex_rf_dump: scenario table plus an expected-beat queue built from the register contents.
module tb_ibex_rf_dump;

`ifdef IBEX_RF_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        start0, start1, abort, ready;
  logic [31:0] mem [32];

  logic [4:0]  raddr0, raddr1, addr0, addr1;
  logic [31:0] rdata0, rdata1, data0, data1;
  logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

  ibex_rf_dump #(.RV32E(1'b0), .DataWidth(32)) dut0 (
    .clk_int(clk_int), .rst_ni(rst_ni), .start_i(start0), .abort_i(abort),
    .raddr_o(raddr0), .rdata_i(rdata0), .out_valid_o(valid0), .out_ready_i(ready),
    .out_data_o(data0), .out_addr_o(addr0), .out_last_o(last0), .busy_o(busy0), .done_o(done0)
  );

  ibex_rf_dump #(.RV32E(1'b1), .DataWidth(32)) dut1 (
    .clk_int(clk_int), .rst_ni(rst_ni), .start_i(start1), .abort_i(abort),
    .raddr_o(raddr1), .rdata_i(rdata1), .out_valid_o(valid1), .out_ready_i(ready),
    .out_data_o(data1), .out_addr_o(addr1), .out_last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  always #5 clk_int = ~clk_int;

  logic        sel;
  logic        v, l, b, d;
  logic [31:0] dat;
  logic [4:0]  ad, ra;
  assign v   = sel ? valid1 : valid0;
  assign l   = sel ? last1  : last0;
  assign b   = sel ? busy1  : busy0;
  assign d   = sel ? done1  : done0;
  assign dat = sel ? data1  : data0;
  assign ad  = sel ? addr1  : addr0;
  assign ra  = sel ? raddr1 : raddr0;

  typedef struct {
    bit e;
    int fill;
    int rmode;
    int abort_beat;
    bit spam;
    int exp_beats;
    int exp_lat;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] dt;
    bit          last;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_beat_data;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    beat_t       q[$];
    beat_t       bt;
    logic [31:0] x;
    int          n, accepted, dones, done_cyc, aborted, finish_at;
    logic        prev_v, prev_r, prev_l, prev_abort, hs;
    logic [31:0] prev_dat;
    logic [4:0]  prev_ad, prev_ra;
    bit          ended;

    sel = t.e;
    n = t.e ? 16 : 32;
    for (int i = 0; i < 32; i++) begin
      case (t.fill)
        0:       mem[i] = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
        1:       mem[i] = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
        default: mem[i] = $urandom;
      endcase
    end

    // Expected stream: every register in address order, then the XOR beat when enabled.
    x = '0;
    for (int i = 0; i < n; i++) begin
      bt.a = 5'(i); bt.dt = mem[i]; bt.last = (CS == 0) && (i == n - 1);
      q.push_back(bt);
      x ^= mem[i];
    end
    if (CS == 1) begin
      bt.a = 5'd0; bt.dt = x; bt.last = 1'b1;
      q.push_back(bt);
    end

    accepted = 0; dones = 0; done_cyc = -1; aborted = -1; finish_at = -1; ended = 0;
    prev_v = 0; prev_r = 1; prev_l = 0; prev_abort = 0; prev_dat = '0; prev_ad = '0; prev_ra = '0;

    for (int c = 0; c < 600 && !ended; c++) begin
      start0 = 0; start1 = 0; abort = 0;
      case (t.rmode)
        0:       ready = 1'b1;
        1:       ready = (c % 4 == 0) || (c % 4 == 3);
        default: ready = 1'($urandom_range(1, 0));
      endcase
      if (c == 0) begin
        if (t.e) start1 = 1'b1; else start0 = 1'b1;
      end else if (t.spam && b && $urandom_range(1, 0) == 1) begin
        if (t.e) start1 = 1'b1; else start0 = 1'b1;
      end
      if (t.abort_beat >= 0 && aborted < 0 && v && accepted == t.abort_beat - 1) begin
        ready = 1'b0;
        abort = 1'b1;
        aborted = c;
      end

      @(negedge clk_int);
      hs = v && ready;
      if (prev_v && !prev_r && !prev_abort) begin
        checkOutput("hold_valid", 64'(v), 64'(1));
        checkOutput("hold_data", 64'(dat), 64'(prev_dat));
        checkOutput("hold_addr", 64'(ad), 64'(prev_ad));
        checkOutput("hold_last", 64'(l), 64'(prev_l));
        checkOutput("hold_raddr", 64'(ra), 64'(prev_ra));
      end
      if (t.e && b) checkOutput("raddr_bit4", 64'(ra[4]), 64'(0));
      if (hs) begin
        if (q.size() == 0) begin
          checkOutput("extra_beat", 64'(1), 64'(0));
        end else begin
          bt = q.pop_front();
          checkOutput("beat_addr", 64'(ad), 64'(bt.a));
          checkOutput("beat_data", 64'(dat), 64'(bt.dt));
          checkOutput("beat_last", 64'(l), 64'(bt.last));
          last_beat_data = dat;
        end
        accepted++;
      end
      if (d) begin
        dones++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c > done_cyc) begin
        checkOutput("idle_busy", 64'(b), 64'(0));
        checkOutput("idle_valid", 64'(v), 64'(0));
      end
      if (aborted >= 0 && c > aborted) begin
        checkOutput("abort_valid", 64'(v), 64'(0));
        checkOutput("abort_busy", 64'(b), 64'(0));
      end
      prev_v = v; prev_r = ready; prev_l = l; prev_dat = dat; prev_ad = ad; prev_ra = ra; prev_abort = abort;
      if (finish_at < 0 && (done_cyc >= 0 || aborted >= 0)) finish_at = c + 4;

      @(posedge clk_int);
      #1;
      if (c == finish_at) ended = 1;
    end

    start0 = 0; start1 = 0; abort = 0;
    if (!ended) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: dump did not complete within cycle budget");
    end
    checkOutput("beat_count", 64'(accepted), 64'(t.exp_beats));
    checkOutput("done_count", 64'(dones), 64'((t.abort_beat >= 0) ? 0 : 1));
    if (t.exp_lat >= 0) checkOutput("latency", 64'(done_cyc), 64'(t.exp_lat));
    if (t.fill == 1) checkOutput("final_beat_data", 64'(last_beat_data), 64'(32'hFFFF_FFFF));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 0, 0, -1, 1'b0, 32 + CS, 34 + CS};
    vecs[1] = '{1'b0, 2, 1, -1, 1'b0, 32 + CS, -1};
    vecs[2] = '{1'b1, 0, 0, -1, 1'b0, 16 + CS, 18 + CS};
    vecs[3] = '{1'b1, 2, 2, -1, 1'b0, 16 + CS, -1};
    vecs[4] = '{1'b0, 2, 1, 10, 1'b0, 9, -1};
    vecs[5] = '{1'b0, 0, 0, -1, 1'b1, 32 + CS, 34 + CS};
    vecs[6] = '{1'b0, 1, 0, -1, 1'b0, 32 + CS, 34 + CS};
    vecs[7] = '{1'b0, 2, 2, -1, 1'b1, 32 + CS, -1};

    sel = 0; rst_ni = 0; start0 = 0; start1 = 0; abort = 0; ready = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #12;
    checkOutput("rst_valid", 64'(valid0), 64'(0));
    checkOutput("rst_data", 64'(data0), 64'(0));
    checkOutput("rst_addr", 64'(addr0), 64'(0));
    checkOutput("rst_last", 64'(last0), 64'(0));
    checkOutput("rst_busy", 64'(busy0), 64'(0));
    checkOutput("rst_done", 64'(done0), 64'(0));
    checkOutput("rst_raddr", 64'(raddr0), 64'(0));
    checkOutput("rst_valid_e", 64'(valid1), 64'(0));
    checkOutput("rst_busy_e", 64'(busy1), 64'(0));
    @(negedge clk_int);
    rst_ni = 1;
    @(posedge clk_int);
    #1;

    // start together with abort in IDLE must not launch a dump
    start0 = 1; abort = 1; ready = 1;
    @(posedge clk_int);
    #1;
    start0 = 0; abort = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_int);
      checkOutput("start_abort_busy", 64'(busy0), 64'(0));
      checkOutput("start_abort_valid", 64'(valid0), 64'(0));
      @(posedge clk_int);
      #1;
    end

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
